pipe_ctrl: RTL

Pipeline sequencing controller for the picoMIPS core. It sits beside the IF/ID/EX/WB datapath and generates PC stall/redirect, IF/ID hold/flush, ID/EX bubble and EX hold. It arbitrates between four sources: branch redirect, multi-cycle multiply occupancy, load-free RAW hazards, and the WAIT-on-SW8 instruction. It also synchronises the SW8 switch and counts stall cycles for debug.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pipe_ctrl_sw_sync.sv | 87 ++++++++
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and default sizes for the picoMIPS pipeline control logic.
//   pipe_state_t     : sequencing FSM states (RUN / MUL_BUSY / SW_WAIT)
//   CPU_PC_WIDTH     : default program counter width
//   CPU_REG_ADDR_W   : default register index width
//   CPU_MUL_CYCLES   : default number of cycles a multiply occupies EX
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_PC_WIDTH   = 6;
    localparam int CPU_REG_ADDR_W = 3;
    localparam int CPU_MUL_CYCLES = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        SW_WAIT  = 2'd2
    } pipe_state_t;

endpackage : cpu_pkg

// File: rtl/pipe_ctrl_sw_sync.sv
// -----------------------------------------------------------------------------
// sw_sync
// Brings the asynchronous SW8 switch into the clock domain and produces a
// level plus a one-cycle rising-edge pulse.
// Optional build macro: PIPE_CTRL_DEBOUNCE_EN adds a stable-count debouncer
// behind the synchroniser.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-low reset
//   sw_i    in  raw switch input (asynchronous)
//   level_o out synchronised (optionally debounced) level
//   rise_o  out high for the cycle in which level_o is 1 and was 0 before
// -----------------------------------------------------------------------------
module sw_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("sw_sync: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("sw_sync: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef PIPE_CTRL_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          level_q;
    logic [DW-1:0] deb_cnt_q;

    // The level follows the synchronised input only after it has disagreed
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else if (synced != level_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                level_q   <= synced;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_q <= '0;
        end
    end

    assign level = level_q;
`else
    assign level = synced;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;

endmodule : sw_sync

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the picoMIPS IF/ID/EX/WB datapath.
// Arbitrates branch redirect > multiply occupancy > RAW hazard > WAIT-on-SW8
// and drives PC / IF-ID / ID-EX / EX control, plus a saturating stall counter.
// Optional build macro: PIPE_CTRL_DEBOUNCE_EN (debounced SW8, see sw_sync).
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   sw8_in                  raw SW8 switch
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_wait   ID info
//   ex_wr_en, ex_rd, ex_is_mul, ex_branch_taken, ex_branch_target EX info
//   pc_stall, pc_sel, pc_target                PC control
//   if_id_stall, if_id_flush                   IF/ID control
//   id_ex_bubble, ex_hold                      ID/EX and EX control
//   sw8_sync, state_o, stall_cycles            debug / status
// -----------------------------------------------------------------------------
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH        = CPU_PC_WIDTH,
    parameter int REG_ADDR_WIDTH  = CPU_REG_ADDR_W,
    parameter int MUL_CYCLES      = CPU_MUL_CYCLES,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sw8_in,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_uses_rs,
    input  logic                      id_uses_rt,
    input  logic                      id_is_wait,
    input  logic                      ex_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_is_mul,
    input  logic                      ex_branch_taken,
    input  logic [PC_WIDTH-1:0]       ex_branch_target,
    output logic                      pc_stall,
    output logic                      pc_sel,
    output logic [PC_WIDTH-1:0]       pc_target,
    output logic                      if_id_stall,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic                      ex_hold,
    output logic                      sw8_sync,
    output logic [1:0]                state_o,
    output logic [15:0]               stall_cycles
);

    if (MUL_CYCLES < 2) begin : g_bad_mul
        $error("pipe_ctrl: MUL_CYCLES must be >= 2");
    end

    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;

    pipe_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_q;
    logic             sw8_rise;
    logic             raw_hit;

    sw_sync #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_sync (
        .clk    (clk),
        .reset  (reset),
        .sw_i   (sw8_in),
        .level_o(sw8_sync),
        .rise_o (sw8_rise)
    );

    // Register 0 is hard-wired zero, so a write to it never creates a hazard.
    assign raw_hit = id_valid & ex_wr_en & (ex_rd != '0) &
                     ((id_uses_rs & (id_rs == ex_rd)) |
                      (id_uses_rt & (id_rt == ex_rd)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_stall     = 1'b0;
        pc_sel       = 1'b0;
        pc_target    = '0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    // ID is flushed, so any hazard or WAIT there is moot.
                    pc_sel       = 1'b1;
                    pc_target    = ex_branch_target;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (ex_is_mul) begin
                    ex_hold     = 1'b1;
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    state_d     = MUL_BUSY;
                    cnt_d       = CNT_W'(MUL_CYCLES - 2);
                end else if (raw_hit) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (id_valid && id_is_wait) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = SW_WAIT;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != '0) begin
                    ex_hold     = 1'b1;
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            SW_WAIT: begin
                // Only a fresh edge releases; a level already high on entry
                // produced its edge before we got here.
                if (sw8_rise) begin
                    state_d = RUN;
                end else begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Outputs are forced quiet while reset is asserted.
        if (!reset) begin
            pc_stall     = 1'b0;
            pc_sel       = 1'b0;
            pc_target    = '0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            ex_hold      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pc_stall && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign state_o      = state_q;
    assign stall_cycles = stall_q;

endmodule : pipe_ctrl
